dest_tracker: RTL and testbench
===============================

# dest_tracker

Tracks the destination register of every in-flight instruction from issue (leaving ID) through EX, MEM, WB and register-file write, and drives the `dest_ex`/`dest_mem`/`dest_wb`/`dest_reg` tags that the hazard detector compares against source operands. It advances the tag pipeline in lock-step with the datapath. It inserts a bubble (tag 0) when the hazard detector raises `stall` or when a branch flush kills the issuing instruction. It also freezes all tags during a global pipeline hold.

## Interface
- `REG_BITS`, 3: register index width; register 0 is hardwired zero and is never tracked.
- `CNT_W`, 16: width of the statistics counters.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous and active-high.
- `issue_valid`  in  1  the ID stage presents an instruction this cycle.
- `issue_wb_en`  in  1  the issuing instruction writes the register file.
- `issue_dest`  in  REG_BITS  destination register index of the issuing instruction.
- `stall`  in  1  stall request from the hazard detector; the ID instruction does not advance.
- `flush`  in  1  branch taken; the ID instruction is killed.
- `hold`  in  1  global pipeline freeze (memory wait); no stage advances.
- `dest_ex`, `dest_mem`, `dest_wb`, `dest_reg`  out  REG_BITS each  registered tag per stage; 0 means no pending write.
- `pending_mask`  out  2**REG_BITS  bit i is set when any of the four tags equals i (i≠0); bit 0 is always 0.
- `busy`  out  1  OR of `pending_mask`.
- `stall_cycles`  out  CNT_W  saturating count of stall cycles.
- `bubble_count`  out  CNT_W  saturating count of inserted bubbles.

## Operation
- **Reset:** all four tags, both counters, `pending_mask` and `busy` are 0.
- **Next issue tag:** `issue_dest` when `issue_valid & issue_wb_en & ~stall & ~flush & (issue_dest != 0)`, else 0.
- **Per-cycle priority:** `rst` > `hold` > normal shift.
- **Normal shift:** `dest_reg <= dest_wb`, `dest_wb <= dest_mem`, `dest_mem <= dest_ex`, `dest_ex <= next issue tag`.
- **Hold:** all tags keep their values. `stall` and `flush` are ignored that cycle. No counter increments.
- **Bubble:** a bubble is a shift cycle in which `issue_valid & (stall | flush)`. Stall and flush together count as one bubble.
- **Non-writing instructions:** an instruction with `issue_wb_en` = 0, or a write to r0, enters as tag 0. This is not a bubble.
- **Duplicate tags:** the same register may occupy several stages; `pending_mask` stays set until the last copy leaves `dest_reg`.
- **`pending_mask` and `busy`** are combinational from the four registered tags; they carry no extra state.

## Timing
- **Latency:** issue tag appears on `dest_ex` 1 cycle after issue, `dest_mem` after 2, `dest_wb` after 3, `dest_reg` after 4. It clears from all outputs 5 cycles after issue, absent hold.
- **Feedback loop:** `stall` arrives combinationally in the same cycle from the hazard detector. The tracker adds no combinational path from `stall`/`flush`/`hold` to any output, so the loop has no combinational cycle.
- **Sustained stall:** each stalled cycle shifts a 0 into `dest_ex`, draining older tags. A stalled dependency therefore resolves within at most 4 cycles.
- **Reset mid-operation:** all tags are cleared on the next edge regardless of `hold`.
- **Counters:** saturate at 2**CNT_W−1 and do not wrap.

## Configuration
- `DEST_TRACKER_STATS_EN` defined: `stall_cycles` increments on each non-hold cycle with `stall` = 1. `bubble_count` increments on each bubble as defined above.
- Macro not defined: counter registers are not built; `stall_cycles` and `bubble_count` are tied to 0. Tag behaviour is identical in both builds.

## Test plan
- **Basic flow:** reset, then issue r3 with wb_en at cycle 0 → `dest_ex`=3 @1, `dest_mem`=3 @2, `dest_wb`=3 @3, `dest_reg`=3 @4, all 0 and `busy`=0 @5.
- **Stall bubble:** issue r5, then present r5 again with `stall`=1 for 2 cycles → `dest_ex`=0 on both following cycles, r5 advances to `dest_wb`. With STATS_EN: `stall_cycles`=2, `bubble_count`=2.
- **Hold:** tags 1/2/3/4 in ex/mem/wb/reg, `hold`=1 for 3 cycles with `stall`=1 → tags unchanged, counters unchanged. Release → normal shift resumes.
- **Flush, zero dest, no write:** issue r6 with `flush`=1 → `dest_ex`=0. Issue r0 → 0. Issue r7 with wb_en=0 → 0. Only the flush counts as a bubble.
- **Duplicate tags and reset:** issue r2 twice back-to-back → `pending_mask`=8'h04 until the second copy leaves `dest_reg`. Assert `rst` mid-stream with `hold`=1 → all outputs 0 next cycle.
- **Saturation:** build with CNT_W=4, hold `stall`=1 for 20 cycles → `stall_cycles`=15 and stays 15.

Source files
------------

// File: rtl/dest_tracker.sv
// Destination-tag pipeline that mirrors EX/MEM/WB/REG for hazard detection.
// Optional statistics counters are built when DEST_TRACKER_STATS_EN is defined.
module dest_tracker #(
  parameter int unsigned REG_BITS = 3,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     issue_valid,
  input  logic                     issue_wb_en,
  input  logic [REG_BITS-1:0]      issue_dest,
  input  logic                     stall,
  input  logic                     flush,
  input  logic                     hold,
  output logic [REG_BITS-1:0]      dest_ex,
  output logic [REG_BITS-1:0]      dest_mem,
  output logic [REG_BITS-1:0]      dest_wb,
  output logic [REG_BITS-1:0]      dest_reg,
  output logic [2**REG_BITS-1:0]   pending_mask,
  output logic                     busy,
  output logic [CNT_W-1:0]         stall_cycles,
  output logic [CNT_W-1:0]         bubble_count
);

  localparam int unsigned NumRegs = 2 ** REG_BITS;

  logic [REG_BITS-1:0] next_tag;

  // Stalled, flushed, non-writing and r0-writing instructions all enter as tag 0.
  always_comb begin
    next_tag = '0;
    if (issue_valid && issue_wb_en && !stall && !flush && (issue_dest != '0)) begin
      next_tag = issue_dest;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dest_ex  <= '0;
      dest_mem <= '0;
      dest_wb  <= '0;
      dest_reg <= '0;
    end else if (!hold) begin
      dest_reg <= dest_wb;
      dest_wb  <= dest_mem;
      dest_mem <= dest_ex;
      dest_ex  <= next_tag;
    end
  end

  // Bit 0 stays clear: r0 never represents a pending write.
  always_comb begin
    pending_mask = '0;
    for (int unsigned i = 1; i < NumRegs; i++) begin
      if ((dest_ex == REG_BITS'(i)) || (dest_mem == REG_BITS'(i)) ||
          (dest_wb == REG_BITS'(i)) || (dest_reg == REG_BITS'(i))) begin
        pending_mask[i] = 1'b1;
      end
    end
  end

  assign busy = |pending_mask;

`ifdef DEST_TRACKER_STATS_EN
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] bubble_q;
  logic             bubble;

  assign bubble = issue_valid && (stall || flush);

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q  <= '0;
      bubble_q <= '0;
    end else if (!hold) begin
      if (stall && (stall_q != {CNT_W{1'b1}})) begin
        stall_q <= stall_q + CNT_W'(1);
      end
      if (bubble && (bubble_q != {CNT_W{1'b1}})) begin
        bubble_q <= bubble_q + CNT_W'(1);
      end
    end
  end

  assign stall_cycles = stall_q;
  assign bubble_count = bubble_q;
`else
  assign stall_cycles = '0;
  assign bubble_count = '0;
`endif

endmodule

// File: tb/tb_dest_tracker.sv
// Directed plus randomized bench for dest_tracker, checked against a queue-based age model.
module tb_dest_tracker;

  logic       clk = 1'b0;
  logic       rst, issue_valid, issue_wb_en, stall, flush, hold;
  logic [2:0] issue_dest;

  logic [2:0]  dest_ex, dest_mem, dest_wb, dest_reg;
  logic [7:0]  pending_mask;
  logic        busy;
  logic [15:0] stall_cycles, bubble_count;

  logic [2:0]  d4_ex, d4_mem, d4_wb, d4_reg;
  logic [7:0]  d4_mask;
  logic        d4_busy;
  logic [3:0]  d4_stall_cycles, d4_bubble_count;

  dest_tracker #(.REG_BITS(3), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_wb_en(issue_wb_en),
    .issue_dest(issue_dest), .stall(stall), .flush(flush), .hold(hold),
    .dest_ex(dest_ex), .dest_mem(dest_mem), .dest_wb(dest_wb), .dest_reg(dest_reg),
    .pending_mask(pending_mask), .busy(busy),
    .stall_cycles(stall_cycles), .bubble_count(bubble_count)
  );

  dest_tracker #(.REG_BITS(3), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_wb_en(issue_wb_en),
    .issue_dest(issue_dest), .stall(stall), .flush(flush), .hold(hold),
    .dest_ex(d4_ex), .dest_mem(d4_mem), .dest_wb(d4_wb), .dest_reg(d4_reg),
    .pending_mask(d4_mask), .busy(d4_busy),
    .stall_cycles(d4_stall_cycles), .bubble_count(d4_bubble_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // Model: queue of tags ordered youngest first; counters as plain integers.
  int pipe[$];
  int m_stall16, m_bub16, m_stall4, m_bub4;

`ifdef DEST_TRACKER_STATS_EN
  localparam bit StatsOn = 1'b1;
`else
  localparam bit StatsOn = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
  endtask

  function automatic int sat_inc(input int v, input int lim);
    return (v < lim) ? v + 1 : v;
  endfunction

  function automatic logic [7:0] model_mask();
    logic [7:0] m = '0;
    foreach (pipe[k]) if (pipe[k] != 0) m[pipe[k]] = 1'b1;
    return m;
  endfunction

  task automatic model_edge(input logic v, we, input int d, input logic s, f, h, r);
    int nt;
    if (r) begin
      pipe = '{0, 0, 0, 0};
      m_stall16 = 0; m_bub16 = 0; m_stall4 = 0; m_bub4 = 0;
    end else if (!h) begin
      nt = (v && we && !s && !f && d != 0) ? d : 0;
      pipe.push_front(nt);
      void'(pipe.pop_back());
      if (s) begin
        m_stall16 = sat_inc(m_stall16, 65535);
        m_stall4  = sat_inc(m_stall4, 15);
      end
      if (v && (s || f)) begin
        m_bub16 = sat_inc(m_bub16, 65535);
        m_bub4  = sat_inc(m_bub4, 15);
      end
    end
  endtask

  task automatic check_all(input string tag);
    logic [7:0] em = model_mask();
    check({tag, ".ex"},   32'(dest_ex),  32'(pipe[0]));
    check({tag, ".mem"},  32'(dest_mem), 32'(pipe[1]));
    check({tag, ".wb"},   32'(dest_wb),  32'(pipe[2]));
    check({tag, ".reg"},  32'(dest_reg), 32'(pipe[3]));
    check({tag, ".mask"}, 32'(pending_mask), 32'(em));
    check({tag, ".busy"}, 32'(busy), 32'(em != 0));
    check({tag, ".sc"},   32'(stall_cycles), StatsOn ? 32'(m_stall16) : 32'd0);
    check({tag, ".bc"},   32'(bubble_count), StatsOn ? 32'(m_bub16) : 32'd0);
    check({tag, ".ex4"},  32'(d4_ex), 32'(pipe[0]));
    check({tag, ".reg4"}, 32'(d4_reg), 32'(pipe[3]));
    check({tag, ".sc4"},  32'(d4_stall_cycles), StatsOn ? 32'(m_stall4) : 32'd0);
    check({tag, ".bc4"},  32'(d4_bubble_count), StatsOn ? 32'(m_bub4) : 32'd0);
  endtask

  // Drive one cycle of inputs, clock it, update the model, then sample 1 time unit later.
  task automatic step(input string tag, input logic v, we, input int d,
                      input logic s, f, h, r);
    issue_valid = v; issue_wb_en = we; issue_dest = 3'(d);
    stall = s; flush = f; hold = h; rst = r;
    @(posedge clk);
    model_edge(v, we, d, s, f, h, r);
    #1;
    check_all(tag);
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    pipe = '{0, 0, 0, 0};
    m_stall16 = 0; m_bub16 = 0; m_stall4 = 0; m_bub4 = 0;
    #2;

    // Reset
    step("reset", 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    step("reset", 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("reset.ex_const", 32'(dest_ex), 32'd0);

    // Basic flow: r3 walks through all four stages and clears on cycle 5
    step("basic", 1'b1, 1'b1, 3, 1'b0, 1'b0, 1'b0, 1'b0);
    check("basic.ex@1", 32'(dest_ex), 32'd3);
    idle("basic"); check("basic.mem@2", 32'(dest_mem), 32'd3);
    idle("basic"); check("basic.wb@3",  32'(dest_wb), 32'd3);
    idle("basic"); check("basic.reg@4", 32'(dest_reg), 32'd3);
    idle("basic"); check("basic.busy@5", 32'(busy), 32'd0);

    // Stall bubble
    step("srst", 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    step("stall", 1'b1, 1'b1, 5, 1'b0, 1'b0, 1'b0, 1'b0);
    step("stall", 1'b1, 1'b1, 5, 1'b1, 1'b0, 1'b0, 1'b0);
    check("stall.ex0a", 32'(dest_ex), 32'd0);
    step("stall", 1'b1, 1'b1, 5, 1'b1, 1'b0, 1'b0, 1'b0);
    check("stall.ex0b", 32'(dest_ex), 32'd0);
    check("stall.wb5", 32'(dest_wb), 32'd5);
    check("stall.sc2", 32'(stall_cycles), StatsOn ? 32'd2 : 32'd0);
    check("stall.bc2", 32'(bubble_count), StatsOn ? 32'd2 : 32'd0);

    // Hold: load 1/2/3/4 into ex/mem/wb/reg, then freeze with stall asserted
    step("hload", 1'b1, 1'b1, 4, 1'b0, 1'b0, 1'b0, 1'b0);
    step("hload", 1'b1, 1'b1, 3, 1'b0, 1'b0, 1'b0, 1'b0);
    step("hload", 1'b1, 1'b1, 2, 1'b0, 1'b0, 1'b0, 1'b0);
    step("hload", 1'b1, 1'b1, 1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step("hold", 1'b1, 1'b1, 6, 1'b1, 1'b1, 1'b1, 1'b0);
    check("hold.tags", {20'd0, dest_ex, dest_mem, dest_wb, dest_reg}, {20'd0, 12'o1234});
    check("hold.sc", 32'(stall_cycles), StatsOn ? 32'd2 : 32'd0);
    idle("release");
    check("release.reg", 32'(dest_reg), 32'd3);

    // Flush, zero dest, non-writing
    step("flush", 1'b1, 1'b1, 6, 1'b0, 1'b1, 1'b0, 1'b0);
    check("flush.ex", 32'(dest_ex), 32'd0);
    step("r0", 1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("nowb", 1'b1, 1'b0, 7, 1'b0, 1'b0, 1'b0, 1'b0);
    check("nowb.ex", 32'(dest_ex), 32'd0);
    check("flush.bc3", 32'(bubble_count), StatsOn ? 32'd3 : 32'd0);

    // Duplicate tags: mask stays 0x04 until the second r2 leaves dest_reg
    step("drst", 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    step("dup", 1'b1, 1'b1, 2, 1'b0, 1'b0, 1'b0, 1'b0);
    step("dup", 1'b1, 1'b1, 2, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check("dup.mask", 32'(pending_mask), 32'h04);
      idle("dup");
    end
    check("dup.clear", 32'(pending_mask), 32'h00);
    step("rhold", 1'b1, 1'b1, 3, 1'b0, 1'b0, 1'b0, 1'b0);
    step("rhold", 1'b1, 1'b1, 3, 1'b0, 1'b0, 1'b1, 1'b1);
    check("rhold.busy", 32'(busy), 32'd0);

    // Saturation of the 4-bit counter
    for (int i = 0; i < 20; i++) step("sat", 1'($urandom_range(1)), 1'b1, 5, 1'b1, 1'b0, 1'b0, 1'b0);
    check("sat.sc4", 32'(d4_stall_cycles), StatsOn ? 32'd15 : 32'd0);
    check("sat.sc16", 32'(stall_cycles), StatsOn ? 32'd20 : 32'd0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step("rand", 1'($urandom_range(3) != 0), 1'($urandom_range(3) != 0),
           int'($urandom_range(7)), 1'($urandom_range(3) == 0),
           1'($urandom_range(7) == 0), 1'($urandom_range(4) == 0),
           1'($urandom_range(49) == 0));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
